// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and constants for the minutes:seconds stopwatch.
package stopwatch_ctrl_pkg;

  // Control FSM encoding; 2'd3 is unused and recovers to idle.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2
  } sw_state_e;

  // Largest displayable seconds and minutes values.
  localparam logic [7:0] MAX_SEC = 8'd59;
  localparam logic [7:0] MAX_MIN = 8'd59;

  // Defaults for a 50 MHz clock: one-second prescale and 20 ms key debounce.
  localparam int unsigned CNT_1S_DEFAULT  = 50_000_000;
  localparam int unsigned DEB_CNT_DEFAULT = 1_000_000;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronise, debounce and edge-detect one raw active-low push-button.
// Emits a single-cycle key_press on an accepted 1->0 transition only.
module key_debounce
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CNT = DEB_CNT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_press
);

  localparam int unsigned CW = cnt_width(DEB_CNT);
  localparam logic [CW-1:0] CntMax = CW'(DEB_CNT - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          stable_d;
  logic          stable_dly_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Two-flop synchroniser; resets to the released level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive cycles the synchronised level disagrees with the accepted one.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  // Registered falling-edge detect on the accepted level; releases are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_dly_q <= 1'b1;
      press_q      <= 1'b0;
    end else begin
      stable_dly_q <= stable_q;
      press_q      <= stable_dly_q & ~stable_q;
    end
  end

  assign key_press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Minutes:seconds stopwatch with start/pause and clear buttons.
// dat1 = minutes, dat2 = seconds, both binary 0..59 and registered.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned CNT_1S  = CNT_1S_DEFAULT,
  parameter int unsigned DEB_CNT = DEB_CNT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_start,
  input  logic       key_clr,
  output logic [7:0] dat1,
  output logic [7:0] dat2,
  output logic       running
);

  localparam int unsigned PW = cnt_width(CNT_1S);
  localparam logic [PW-1:0] PrescMax = PW'(CNT_1S - 1);

  logic          start_press;
  logic          clr_press;
  sw_state_e     state_q;
  logic          running_q;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic          tick;
  logic [7:0]    sec_q;
  logic [7:0]    sec_d;
  logic [7:0]    min_q;
  logic [7:0]    min_d;

  key_debounce #(
    .DEB_CNT (DEB_CNT)
  ) u_deb_start (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_start),
    .key_press (start_press)
  );

  key_debounce #(
    .DEB_CNT (DEB_CNT)
  ) u_deb_clr (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_clr),
    .key_press (clr_press)
  );

  // Control FSM with running registered alongside the state; clear beats start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      running_q <= 1'b0;
    end else if (clr_press) begin
      state_q   <= StIdle;
      running_q <= 1'b0;
    end else if (start_press) begin
      case (state_q)
        StIdle, StPause: begin
          state_q   <= StRun;
          running_q <= 1'b1;
        end
        StRun: begin
          state_q   <= StPause;
          running_q <= 1'b0;
        end
        default: begin
          state_q   <= StIdle;
          running_q <= 1'b0;
        end
      endcase
    end else if (state_q != StIdle && state_q != StRun && state_q != StPause) begin
      state_q   <= StIdle;
      running_q <= 1'b0;
    end
  end

  // One-second tick on the last prescaler count of each second spent in RUN.
  assign tick = (state_q == StRun) && (presc_q == PrescMax);

  // Prescaler: counts in RUN, holds in PAUSE so a resume finishes the partial second.
  always_comb begin
    presc_d = presc_q;
    if (clr_press) begin
      presc_d = '0;
    end else begin
      case (state_q)
        StRun:   presc_d = tick ? '0 : presc_q + 1'b1;
        StPause: presc_d = presc_q;
        default: presc_d = '0;
      endcase
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // Seconds/minutes advance on tick, wrapping 59:59 -> 00:00; clear beats tick.
  always_comb begin
    sec_d = sec_q;
    min_d = min_q;
    if (clr_press) begin
      sec_d = '0;
      min_d = '0;
    end else if (tick) begin
      if (sec_q < MAX_SEC) begin
        sec_d = sec_q + 8'd1;
      end else begin
        sec_d = '0;
        min_d = (min_q < MAX_MIN) ? min_q + 8'd1 : '0;
      end
    end
  end

  // Time registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_q <= '0;
      min_q <= '0;
    end else begin
      sec_q <= sec_d;
      min_q <= min_d;
    end
  end

  assign dat1    = min_q;
  assign dat2    = sec_q;
  assign running = running_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with CNT_1S=10 and DEB_CNT=4.
// A key held low from a falling clock edge acts on the 8th rising edge after it.
module tb_stopwatch_ctrl;

  logic       clk;
  logic       rst;
  logic       key_start;
  logic       key_clr;
  logic [7:0] dat1;
  logic [7:0] dat2;
  logic       running;

  int vecs  = 0;
  int fails = 0;

  stopwatch_ctrl #(
    .CNT_1S  (10),
    .DEB_CNT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_start (key_start),
    .key_clr   (key_clr),
    .dat1      (dat1),
    .dat2      (dat2),
    .running   (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_time(input string tag, input logic [7:0] mm, input logic [7:0] ss,
                            input logic run);
    check({tag, ".min"}, dat1, mm);
    check({tag, ".sec"}, dat2, ss);
    check({tag, ".run"}, {7'd0, running}, {7'd0, run});
  endtask

  initial begin
    rst       = 1'b1;
    key_start = 1'b1;
    key_clr   = 1'b1;
    step(3);
    check_time("reset", 8'd0, 8'd0, 1'b0);
    rst = 1'b0;
    step(5);
    check_time("post_reset_idle", 8'd0, 8'd0, 1'b0);

    // Bouncing start key: 3 low / 1 high never lasts long enough.
    for (int i = 0; i < 4; i++) begin
      key_start = 1'b0;
      step(3);
      key_start = 1'b1;
      step(1);
    end
    step(10);
    check_time("bounce_rejected", 8'd0, 8'd0, 1'b0);

    // Clean hold: state changes on exactly the 8th edge.
    key_start = 1'b0;
    step(7);
    check("press_latency_7", {7'd0, running}, 8'd0);
    step(1);
    check("press_latency_8", {7'd0, running}, 8'd1);
    key_start = 1'b1;
    step(8);                                     // 8 RUN edges, no second press
    check_time("single_press", 8'd0, 8'd0, 1'b1);
    step(23);                                    // 31 RUN edges -> 3 s
    check_time("count_3s", 8'd0, 8'd3, 1'b1);

    // Pause lands on RUN edge 39: prescaler parked at 9.
    key_start = 1'b0;
    step(8);
    check_time("paused", 8'd0, 8'd3, 1'b0);
    key_start = 1'b1;
    step(50);
    check_time("pause_hold_50", 8'd0, 8'd3, 1'b0);

    // Resume keeps the partial second: tick one edge later.
    key_start = 1'b0;
    step(8);
    check_time("resumed", 8'd0, 8'd3, 1'b1);
    step(1);
    check("resume_partial_sec", dat2, 8'd4);
    key_start = 1'b1;
    step(8);                                     // k = 9 edges since resume

    // Minute rollover at k = 561.
    step(542);
    check_time("at_00_59", 8'd0, 8'd59, 1'b1);
    step(9);
    check_time("still_00_59", 8'd0, 8'd59, 1'b1);
    step(1);
    check_time("roll_01_00", 8'd1, 8'd0, 1'b1);

    // Full wrap at k = 35961.
    step(35390);
    check_time("at_59_59", 8'd59, 8'd59, 1'b1);
    step(9);
    check_time("still_59_59", 8'd59, 8'd59, 1'b1);
    step(1);
    check_time("wrap_00_00", 8'd0, 8'd0, 1'b1);

    // Coincident start and clear at 02:17: clear wins.
    step(1370);
    check_time("at_02_17", 8'd2, 8'd17, 1'b1);
    key_start = 1'b0;
    key_clr   = 1'b0;
    step(8);
    check_time("clear_beats_start", 8'd0, 8'd0, 1'b0);
    key_start = 1'b1;
    key_clr   = 1'b1;
    step(8);
    check_time("idle_after_both", 8'd0, 8'd0, 1'b0);

    // Clear from PAUSE at 00:08.
    key_start = 1'b0;
    step(8);
    key_start = 1'b1;
    step(8);
    step(70);                                    // 78 RUN edges
    check_time("at_00_07", 8'd0, 8'd7, 1'b1);
    key_start = 1'b0;
    step(8);                                     // pause on edge 86
    key_start = 1'b1;
    check_time("paused_00_08", 8'd0, 8'd8, 1'b0);
    step(8);
    key_clr = 1'b0;
    step(8);
    check_time("clear_in_pause", 8'd0, 8'd0, 1'b0);
    key_clr = 1'b1;
    step(8);

    // Fresh start after clear: first tick exactly 10 edges in.
    key_start = 1'b0;
    step(8);
    check_time("restart", 8'd0, 8'd0, 1'b1);
    step(9);
    check("fresh_tick_9", dat2, 8'd0);
    step(1);
    check("fresh_tick_10", dat2, 8'd1);
    key_start = 1'b1;
    step(8);
    step(32);                                    // 50 RUN edges
    check_time("at_00_05", 8'd0, 8'd5, 1'b1);

    // Asynchronous reset mid-count, sampled before any clock edge.
    #2 rst = 1'b1;
    #1;
    check_time("async_reset", 8'd0, 8'd0, 1'b0);
    step(2);
    rst = 1'b0;
    step(20);
    check_time("idle_after_reset", 8'd0, 8'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
